// File: rtl/ucode_row_iterator.sv
// Expands one row-walk command into a handshaked stream of row offsets with
// modular up/down wrap, first/last markers and a completion pulse.
module ucode_row_iterator #(
  parameter int ROWS_PER_HDVECT = 16,
  parameter int OFFSET_W        = $clog2(ROWS_PER_HDVECT)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [OFFSET_W-1:0] cmd_start_i,
  input  logic [OFFSET_W:0]   cmd_count_i,
  input  logic                cmd_down_i,
  output logic                row_valid_o,
  input  logic                row_ready_i,
  output logic [OFFSET_W-1:0] row_offset_o,
  output logic                row_first_o,
  output logic                row_last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CNT_W = OFFSET_W + 1;
  localparam logic [CNT_W-1:0]    ROWS_C   = CNT_W'(ROWS_PER_HDVECT);
  localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(ROWS_PER_HDVECT - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_first, w_first_nxt;
  logic                r_last, w_last_nxt;
  logic                r_done, w_done_nxt;
  logic [OFFSET_W-1:0] r_offset, w_offset_nxt;
  logic [CNT_W-1:0]    r_remaining, w_remaining_nxt;
  logic                r_down, w_down_nxt;

  logic [OFFSET_W-1:0] w_start_mod;
  logic [CNT_W-1:0]    w_count_eff;

  // Start is below 2*ROWS, so one conditional subtract is a full modulo.
  assign w_start_mod = ({1'b0, cmd_start_i} >= ROWS_C)
                     ? OFFSET_W'({1'b0, cmd_start_i} - ROWS_C)
                     : cmd_start_i;
  assign w_count_eff = (cmd_count_i > ROWS_C) ? ROWS_C : cmd_count_i;

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign row_valid_o  = r_valid;
  assign row_offset_o = r_offset;
  assign row_first_o  = r_first;
  assign row_last_o   = r_last;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

  // NOTE: every next-state value gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_valid_nxt     = r_valid;
    w_busy_nxt      = r_busy;
    w_first_nxt     = r_first;
    w_last_nxt      = r_last;
    w_done_nxt      = 1'b0;
    w_offset_nxt    = r_offset;
    w_remaining_nxt = r_remaining;
    w_down_nxt      = r_down;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (w_count_eff == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_RUN;
            w_valid_nxt     = 1'b1;
            w_busy_nxt      = 1'b1;
            w_offset_nxt    = w_start_mod;
            w_first_nxt     = 1'b1;
            w_last_nxt      = (w_count_eff == CNT_W'(1));
            w_remaining_nxt = w_count_eff;
            w_down_nxt      = cmd_down_i;
          end
        end
      end
      S_RUN: begin
        if (row_ready_i) begin
          if (r_remaining == CNT_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_first_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_remaining_nxt = r_remaining - CNT_W'(1);
            w_first_nxt     = 1'b0;
            w_last_nxt      = (r_remaining == CNT_W'(2));
            if (r_down) begin
              w_offset_nxt = (r_offset == '0) ? LAST_OFF : r_offset - OFFSET_W'(1);
            end else begin
              w_offset_nxt = (r_offset == LAST_OFF) ? '0 : r_offset + OFFSET_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Flush overrides any simultaneous command or row handshake.
    if (clear_i) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_first_nxt = 1'b0;
      w_last_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_offset    <= '0;
      r_remaining <= '0;
      r_down      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_first     <= w_first_nxt;
      r_last      <= w_last_nxt;
      r_done      <= w_done_nxt;
      r_offset    <= w_offset_nxt;
      r_remaining <= w_remaining_nxt;
      r_down      <= w_down_nxt;
    end
  end

endmodule
